// File: rtl/csd_shift_add_mult.sv
// Multiplies signed xIn by a CSD constant read digit-by-digit from the converter's memory (shift-add/sub only).
// Latency: done pulses 2N+1 cycles after the accepted start (19 cycles for N=9); one digit per READ/ACC pair.
// Backpressure: none; start is only honoured in IDLE, and starts while busy or during done are dropped.
module csd_shift_add_mult #(
  parameter int DW = 8,
  parameter int N  = 9,
  parameter int PW = DW + N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [DW-1:0] xIn,
  output logic                 reCsd,
  output logic [3:0]           address,
  input  logic [DW-1:0]        csdData,
  output logic signed [PW-1:0] product,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, READ, ACC, FIN} state_t;

  state_t state, state_nxt;

  logic [3:0]           idx;
  logic signed [DW-1:0] x_q;
  logic signed [1:0]    prev_q;     // previous digit: +1, 0 or -1
  logic signed [1:0]    dig;        // digit decoded from the memory word
  logic                 dig_bad;    // memory word is not a legal digit
  logic                 last;
  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] x_sh;

  assign last  = (idx == 4'(N - 1));
  assign x_ext = {{(PW-DW){x_q[DW-1]}}, x_q};
  assign x_sh  = x_ext <<< idx;

  // Decode the memory word; illegal words count as a zero digit and are flagged.
  always_comb begin
    dig     = 2'sb00;
    dig_bad = 1'b0;
    if (csdData == DW'(1)) begin
      dig = 2'sb01;
    end else if (csdData == {DW{1'b1}}) begin
      dig = 2'sb11;
    end else if (csdData != '0) begin
      dig_bad = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control outputs; memory is read in READ, its data consumed in ACC.
  always_comb begin
    state_nxt = state;
    reCsd     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = READ;
        end
      end
      READ: begin
        reCsd     = 1'b1;
        busy      = 1'b1;
        state_nxt = ACC;
      end
      ACC: begin
        busy      = 1'b1;
        state_nxt = last ? FIN : READ;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address is only meaningful while reading; park it at zero otherwise.
  assign address = reCsd ? idx : 4'd0;

  // Datapath: capture operand on start, accumulate one shifted +/-x per digit, track canonicity.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= 4'd0;
      x_q     <= '0;
      prev_q  <= 2'sb00;
      product <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q     <= xIn;
            product <= '0;
            err     <= 1'b0;
            idx     <= 4'd0;
            prev_q  <= 2'sb00;
          end
        end
        ACC: begin
          case (dig)
            2'sb01:  product <= product + x_sh;
            2'sb11:  product <= product - x_sh;
            default: product <= product;
          endcase
          // Two nonzero digits in a row means the stream is not canonical.
          if (dig_bad || ((dig != 2'sb00) && (prev_q != 2'sb00))) begin
            err <= 1'b1;
          end
          prev_q <= dig;
          if (!last) begin
            idx <= idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
